// File: rtl/vend_pkg.sv
// Shared encodings, FSM states, price table and payout helpers for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {StIdle, StCredit, StDispense, StChange} state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int unsigned NUM_PRICES = 4;
  localparam int unsigned PRICE [NUM_PRICES] = '{3, 4, 5, 6};

  // Unknown products get an unreachable price so they can never be bought.
  function automatic int unsigned price_of(input int unsigned idx);
    if (idx < NUM_PRICES) return PRICE[idx[1:0]];
    return 32'hffff_ffff;
  endfunction

  function automatic logic [1:0] payout_coin(input int unsigned credit);
    return (credit >= 2) ? COIN_10 : COIN_5;
  endfunction

  function automatic logic [1:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_5:  return 2'd1;
      COIN_10: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change payout engine: ejects one coin per change_req/change_ack handshake until credit is zero.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                change_ack,
  output logic                change_req,
  output logic [1:0]          change_coin,
  output logic [1:0]          consume,
  output logic                done
);

  logic       req_q, req_d;
  logic [1:0] coin_q, coin_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      coin_q <= COIN_NONE;
    end else begin
      req_q  <= req_d;
      coin_q <= coin_d;
    end
  end

  // After each ack the request drops for a cycle so the reduced credit is seen before the next coin.
  always_comb begin
    req_d   = req_q;
    coin_d  = coin_q;
    consume = 2'd0;
    if (!active) begin
      req_d  = 1'b0;
      coin_d = COIN_NONE;
    end else if (req_q) begin
      if (change_ack) begin
        req_d   = 1'b0;
        coin_d  = COIN_NONE;
        consume = coin_units(coin_q);
      end
    end else if (credit != '0) begin
      req_d  = 1'b1;
      coin_d = payout_coin(32'(credit));
    end
  end

  always_comb begin
    change_req  = req_q;
    change_coin = coin_q;
    done        = active && !req_q && (credit == '0);
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit accumulation, selection, dispense and change payout.
// Optional refund-on-cancel is enabled by defining VEND_CANCEL_EN.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PROD   = 4,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 8,
  localparam int unsigned PW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          in,
  input  logic                sel_valid,
  input  logic [PW-1:0]       sel_id,
  input  logic                disp_ack,
  input  logic                change_ack,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic                disp_req,
  output logic [PW-1:0]       disp_id,
  output logic                change_req,
  output logic [1:0]          change_coin
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_nack_q, sel_nack_d;
  logic                disp_req_q, disp_req_d;
  logic [PW-1:0]       disp_id_q, disp_id_d;

  logic [31:0] credit_ext, coin_sum, price;
  logic        sel_ok, cancel_hit;
  logic        chg_req, chg_done;
  logic [1:0]  chg_coin, chg_consume;

`ifdef VEND_CANCEL_EN
  assign cancel_hit = cancel && (state_q == StCredit);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  assign credit_ext = 32'(credit_q);
  assign coin_sum   = credit_ext + 32'(coin_units(in));
  assign price      = price_of(32'(sel_id));
  assign sel_ok     = (32'(sel_id) < NUM_PROD) && (credit_ext >= price);

  vend_change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clock       (clock),
    .reset       (reset),
    .active      (state_q == StChange),
    .credit      (credit_q),
    .change_ack  (change_ack),
    .change_req  (chg_req),
    .change_coin (chg_coin),
    .consume     (chg_consume),
    .done        (chg_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      sel_nack_q    <= 1'b0;
      disp_req_q    <= 1'b0;
      disp_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      sel_nack_q    <= sel_nack_d;
      disp_req_q    <= disp_req_d;
      disp_id_q     <= disp_id_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    sel_nack_d    = 1'b0;
    disp_req_d    = disp_req_q;
    disp_id_d     = disp_id_q;
    unique case (state_q)
      StIdle, StCredit: begin
        if (cancel_hit) begin
          state_d       = StChange;
          sel_nack_d    = sel_valid;
          coin_reject_d = (in != COIN_NONE);
        end else if (sel_valid && (state_q == StCredit)) begin
          // Selection sees pre-coin credit; a simultaneous coin is always returned.
          coin_reject_d = (in != COIN_NONE);
          if (sel_ok) begin
            credit_d   = CREDIT_W'(credit_ext - price);
            disp_id_d  = sel_id;
            disp_req_d = 1'b1;
            state_d    = StDispense;
          end else begin
            sel_nack_d = 1'b1;
          end
        end else begin
          sel_nack_d = sel_valid;
          if (in == COIN_BAD) begin
            coin_reject_d = 1'b1;
          end else if (in != COIN_NONE) begin
            if (coin_sum > MAX_CREDIT) begin
              coin_reject_d = 1'b1;
            end else begin
              credit_d = CREDIT_W'(coin_sum);
              state_d  = StCredit;
            end
          end
        end
      end
      StDispense: begin
        coin_reject_d = (in != COIN_NONE);
        sel_nack_d    = sel_valid;
        if (disp_ack && disp_req_q) begin
          disp_req_d = 1'b0;
          state_d    = (credit_q != '0) ? StChange : StIdle;
        end
      end
      StChange: begin
        coin_reject_d = (in != COIN_NONE);
        sel_nack_d    = sel_valid;
        credit_d      = credit_q - CREDIT_W'(chg_consume);
        if (chg_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    credit      = credit_q;
    coin_reject = coin_reject_q;
    sel_nack    = sel_nack_q;
    disp_req    = disp_req_q;
    disp_id     = disp_id_q;
    change_req  = chg_req;
    change_coin = chg_coin;
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Scoreboard bench for vend_txn_controller: expected output events are queued when stimulus is driven.
module tb_vend_txn_controller;
  import vend_pkg::*;

  localparam int EV_REJECT = 100;
  localparam int EV_NACK   = 200;
  localparam int EV_DISP   = 300;
  localparam int EV_CHG    = 400;

  logic       clock, reset;
  logic [1:0] in;
  logic       sel_valid, disp_ack, change_ack, cancel;
  logic [1:0] sel_id;
  logic [3:0] credit;
  logic       coin_reject, sel_nack, disp_req, change_req;
  logic [1:0] disp_id, change_coin;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];
  logic disp_prev = 1'b0;
  logic chg_prev  = 1'b0;

  vend_txn_controller #(
    .NUM_PROD   (4),
    .CREDIT_W   (4),
    .MAX_CREDIT (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .disp_ack    (disp_ack),
    .change_ack  (change_ack),
    .cancel      (cancel),
    .credit      (credit),
    .coin_reject (coin_reject),
    .sel_nack    (sel_nack),
    .disp_req    (disp_req),
    .disp_id     (disp_id),
    .change_req  (change_req),
    .change_coin (change_coin)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input int got);
    if (sb_q.size() == 0) check_eq({tag, "_unexpected"}, got, -1);
    else check_eq(tag, got, sb_q.pop_front());
  endtask

  // Output-event monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      disp_prev = 1'b0;
      chg_prev  = 1'b0;
    end else begin
      if (coin_reject) sb_pop("reject", EV_REJECT);
      if (sel_nack) sb_pop("nack", EV_NACK);
      if (disp_req && !disp_prev) sb_pop("disp", EV_DISP + int'(disp_id));
      if (change_req && !chg_prev) sb_pop("change", EV_CHG + int'(change_coin));
      disp_prev = disp_req;
      chg_prev  = change_req;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic coin(input logic [1:0] c);
    in = c;
    cyc();
    in = COIN_NONE;
  endtask

  task automatic sel_coin(input int id, input logic [1:0] c);
    sel_valid = 1'b1;
    sel_id    = 2'(id);
    in        = c;
    cyc();
    sel_valid = 1'b0;
    in        = COIN_NONE;
  endtask

  // Acknowledge every request until the controller is idle with no credit.
  task automatic settle(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 2 && n < 200) begin
      disp_ack   = disp_req;
      change_ack = change_req;
      cyc();
      disp_ack   = 1'b0;
      change_ack = 1'b0;
      n++;
      if (!disp_req && !change_req && credit == 4'd0) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_settle_in_budget"}, int'(n < 200), 1);
  endtask

  initial begin
    reset = 1'b1; in = COIN_NONE; sel_valid = 1'b0; sel_id = 2'd0;
    disp_ack = 1'b0; change_ack = 1'b0; cancel = 1'b0;
    #12;
    check_eq("rst_credit", int'(credit), 0);
    check_eq("rst_disp_req", int'(disp_req), 0);
    check_eq("rst_change_req", int'(change_req), 0);
    check_eq("rst_change_coin", int'(change_coin), 0);
    check_eq("rst_disp_id", int'(disp_id), 0);
    check_eq("rst_pulses", int'({coin_reject, sel_nack}), 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Exact payment, no change.
    coin(COIN_10); coin(COIN_10);
    check_eq("t1_credit4", int'(credit), 4);
    sb_q.push_back(EV_DISP + 1);
    sel_coin(1, COIN_NONE);
    check_eq("t1_credit0", int'(credit), 0);
    check_eq("t1_disp_req", int'(disp_req), 1);
    settle("t1");

    // Overpay by 2 units: one 10 coin back.
    coin(COIN_10); coin(COIN_10); coin(COIN_5);
    check_eq("t2_credit5", int'(credit), 5);
    sb_q.push_back(EV_DISP + 0);
    sb_q.push_back(EV_CHG + int'(COIN_10));
    sel_coin(0, COIN_NONE);
    check_eq("t2_credit2", int'(credit), 2);
    settle("t2");
    check_eq("t2_credit_end", int'(credit), 0);

    // Credit ceiling.
    coin(COIN_10); coin(COIN_10); coin(COIN_10); coin(COIN_5);
    check_eq("t3_credit7", int'(credit), 7);
    sb_q.push_back(EV_REJECT);
    coin(COIN_10);
    check_eq("t3_over_keeps7", int'(credit), 7);
    coin(COIN_5);
    check_eq("t3_credit8", int'(credit), 8);
    sb_q.push_back(EV_DISP + 3);
    sb_q.push_back(EV_CHG + int'(COIN_10));
    sel_coin(3, COIN_NONE);
    settle("t3");

    // Short credit and same-cycle coin + selection.
    coin(COIN_10);
    sb_q.push_back(EV_NACK);
    sel_coin(3, COIN_NONE);
    check_eq("t4_nack_credit2", int'(credit), 2);
    sb_q.push_back(EV_REJECT);
    sb_q.push_back(EV_NACK);
    sel_coin(3, COIN_5);
    check_eq("t4_coin_sel_credit2", int'(credit), 2);
    coin(COIN_5);
    sb_q.push_back(EV_REJECT);
    sb_q.push_back(EV_DISP + 0);
    sel_coin(0, COIN_5);
    check_eq("t4_buy_precoin", int'(credit), 0);
    settle("t4");

    // Illegal coin and selection while idle.
    sb_q.push_back(EV_REJECT);
    coin(COIN_BAD);
    check_eq("t5_bad_coin_credit", int'(credit), 0);
    sb_q.push_back(EV_NACK);
    sel_coin(2, COIN_NONE);

    // Activity during dispense is refused; 5-unit change coin.
    coin(COIN_10); coin(COIN_10); coin(COIN_5);
    sb_q.push_back(EV_DISP + 1);
    sel_coin(1, COIN_NONE);
    sb_q.push_back(EV_REJECT);
    coin(COIN_5);
    sb_q.push_back(EV_NACK);
    sel_coin(0, COIN_NONE);
    check_eq("t6_disp_held", int'(disp_req), 1);
    check_eq("t6_credit1", int'(credit), 1);
    sb_q.push_back(EV_CHG + int'(COIN_5));
    settle("t6");

    // Asynchronous reset mid-dispense.
    coin(COIN_10); coin(COIN_10);
    sb_q.push_back(EV_DISP + 0);
    sel_coin(0, COIN_NONE);
    @(negedge clock);
    #1;
    check_eq("t7_pre_disp_req", int'(disp_req), 1);
    reset = 1'b1;
    #1;
    check_eq("t7_rst_disp_req", int'(disp_req), 0);
    check_eq("t7_rst_credit", int'(credit), 0);
    cyc();
    reset = 1'b0;
    cyc();
    sb_q.push_back(EV_NACK);
    sel_coin(0, COIN_NONE);
    check_eq("t7_idle_credit", int'(credit), 0);

    // Cancel: refund when enabled, ignored otherwise.
    coin(COIN_10); coin(COIN_5);
    check_eq("t8_credit3", int'(credit), 3);
`ifdef VEND_CANCEL_EN
    sb_q.push_back(EV_CHG + int'(COIN_10));
    sb_q.push_back(EV_CHG + int'(COIN_5));
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    settle("t8");
    check_eq("t8_refund_credit", int'(credit), 0);
`else
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    cyc(); cyc();
    check_eq("t8_cancel_ignored", int'(credit), 3);
    check_eq("t8_no_change", int'(change_req), 0);
    sb_q.push_back(EV_DISP + 0);
    sel_coin(0, COIN_NONE);
    settle("t8");
`endif

    cyc(); cyc();
    check_eq("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
